// File: rtl/dro_bank_if.sv
// Strobe and status bundle for the dro_bank storage array.
// The master side drives the strobes; the slave side reports storage and violation status.
interface dro_bank_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]    set;
  logic [CH-1:0]    clr;
  logic             rd;
  logic [CH-1:0]    out;
  logic [CH-1:0]    store;
  logic [CH-1:0]    viol;
  logic [CNT_W-1:0] viol_cnt;

  modport master (output set, clr, rd, input out, store, viol, viol_cnt);
  modport slave  (input set, clr, rd, output out, store, viol, viol_cnt);
endinterface

// File: rtl/dro_bank.sv
// Multi-channel DRO storage cell with per-channel setup/hold window checking
// and a saturating violation counter.
module dro_bank #(
  parameter int CH        = 4,
  parameter int SETUP_CYC = 3,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 8,
  parameter int NDRO      = 0
) (
  input logic        clk,
  input logic        reset_n,
  dro_bank_if.slave  bus
);

  localparam int SA_W = $clog2(SETUP_CYC + 1);
  localparam int RA_W = $clog2(HOLD_CYC + 2);
  localparam logic [SA_W-1:0] SA_MAX = SA_W'(SETUP_CYC);
  localparam logic [RA_W-1:0] RA_MAX = RA_W'(HOLD_CYC + 1);
  localparam logic [RA_W-1:0] RA_HOLD = RA_W'(HOLD_CYC);
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic [CH-1:0]    store_p1, store_nxt;
  logic [CH-1:0]    out_p1, out_nxt;
  logic [CH-1:0]    viol_p1, viol_nxt;
  logic [CNT_W-1:0] cnt_p1, cnt_nxt;
  logic [SA_W-1:0]  set_age [CH];
  logic [SA_W-1:0]  set_age_nxt [CH];
  logic [RA_W-1:0]  rd_age, rd_age_nxt;

  function automatic logic [31:0] popcount(input logic [CH-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < CH; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [31:0] b);
    logic [32:0] sum;
    sum = 33'(a) + 33'(b);
    if (sum > 33'(CNT_MAX)) return CNT_W'(CNT_MAX);
    return CNT_W'(sum);
  endfunction

  always_comb begin
    store_nxt = store_p1;
    viol_nxt  = '0;
    out_nxt   = bus.rd ? store_p1 : '0;
    for (int i = 0; i < CH; i++) begin
      set_age_nxt[i] = set_age[i];
      if (bus.clr[i])                    store_nxt[i] = 1'b0;
      else if (bus.set[i])               store_nxt[i] = 1'b1;
      else if (bus.rd && (NDRO == 0))    store_nxt[i] = 1'b0;

      // A same-cycle set counts as age 0; a same-cycle rd masks the hold check.
      if (bus.rd && (bus.set[i] || (set_age[i] < SA_MAX))) viol_nxt[i] = 1'b1;
      if (bus.set[i] && !bus.rd && (rd_age != '0) && (rd_age <= RA_HOLD))
        viol_nxt[i] = 1'b1;

      if (bus.set[i])                    set_age_nxt[i] = SA_W'(1);
      else if (set_age[i] != SA_MAX)     set_age_nxt[i] = set_age[i] + SA_W'(1);
    end
    rd_age_nxt = rd_age;
    if (bus.rd)                 rd_age_nxt = RA_W'(1);
    else if (rd_age != RA_MAX)  rd_age_nxt = rd_age + RA_W'(1);
    cnt_nxt = sat_add(cnt_p1, popcount(viol_nxt));
  end

  // Stage p1: registered store, readout, violation and counter state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      store_p1 <= '0;
      out_p1   <= '0;
      viol_p1  <= '0;
      cnt_p1   <= '0;
      rd_age   <= RA_MAX;
      for (int i = 0; i < CH; i++) set_age[i] <= SA_MAX;
    end else begin
      store_p1 <= store_nxt;
      out_p1   <= out_nxt;
      viol_p1  <= viol_nxt;
      cnt_p1   <= cnt_nxt;
      rd_age   <= rd_age_nxt;
      for (int i = 0; i < CH; i++) set_age[i] <= set_age_nxt[i];
    end
  end

  assign bus.out      = out_p1;
  assign bus.store    = store_p1;
  assign bus.viol     = viol_p1;
  assign bus.viol_cnt = cnt_p1;

endmodule

// File: tb/tb_dro_bank.sv
// Randomized and directed bench for dro_bank: three configurations (DRO, NDRO,
// narrow counter) share one stimulus stream and are checked against an event-time model.
module tb_dro_bank;
  localparam int CH    = 4;
  localparam int SETUP = 3;
  localparam int HOLD  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] set, clr;
  logic          rd;

  always #5 clk = ~clk;

  dro_bank_if #(.CH(CH), .CNT_W(8)) if0 ();
  dro_bank_if #(.CH(CH), .CNT_W(8)) if1 ();
  dro_bank_if #(.CH(CH), .CNT_W(2)) if2 ();

  assign if0.set = set;  assign if0.clr = clr;  assign if0.rd = rd;
  assign if1.set = set;  assign if1.clr = clr;  assign if1.rd = rd;
  assign if2.set = set;  assign if2.clr = clr;  assign if2.rd = rd;

  dro_bank #(.CH(CH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .CNT_W(8), .NDRO(0))
    u_dro (.clk(clk), .reset_n(reset_n), .bus(if0));
  dro_bank #(.CH(CH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .CNT_W(8), .NDRO(1))
    u_ndro (.clk(clk), .reset_n(reset_n), .bus(if1));
  dro_bank #(.CH(CH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .CNT_W(2), .NDRO(0))
    u_narrow (.clk(clk), .reset_n(reset_n), .bus(if2));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model: absolute cycle stamps of the last set per channel and the last rd.
  int            last_set [CH];
  int            last_rd;
  logic [CH-1:0] mstore [3];
  logic [CH-1:0] eout [3];
  logic [CH-1:0] eviol;
  int            mcnt [3];
  int            ndro_c [3] = '{0, 1, 0};
  int            max_c  [3] = '{255, 255, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  task automatic chk_dut(input int k, input logic [CH-1:0] o, input logic [CH-1:0] s,
                         input logic [CH-1:0] v, input logic [31:0] n);
    chk($sformatf("c%0d_out", k),   32'(o), 32'(eout[k]));
    chk($sformatf("c%0d_store", k), 32'(s), 32'(mstore[k]));
    chk($sformatf("c%0d_viol", k),  32'(v), 32'(eviol));
    chk($sformatf("c%0d_cnt", k),   n,      32'(mcnt[k]));
  endtask

  task automatic step(input logic rn, input logic [CH-1:0] s, input logic [CH-1:0] c,
                      input logic r);
    int age;
    @(negedge clk);
    reset_n = rn; set = s; clr = c; rd = r;
    if (!rn) begin
      for (int ch = 0; ch < CH; ch++) last_set[ch] = -1000;
      last_rd = -1000;
      eviol   = '0;
      for (int k = 0; k < 3; k++) begin
        mstore[k] = '0; eout[k] = '0; mcnt[k] = 0;
      end
    end else begin
      eviol = '0;
      for (int ch = 0; ch < CH; ch++) begin
        if (s[ch]) last_set[ch] = cyc;
        age = cyc - last_set[ch];
        if (r && age < SETUP) eviol[ch] = 1'b1;
        if (s[ch] && !r && (cyc - last_rd) >= 1 && (cyc - last_rd) <= HOLD) eviol[ch] = 1'b1;
      end
      if (r) last_rd = cyc;
      for (int k = 0; k < 3; k++) begin
        eout[k] = r ? mstore[k] : '0;
        for (int ch = 0; ch < CH; ch++) begin
          if (c[ch])                        mstore[k][ch] = 1'b0;
          else if (s[ch])                   mstore[k][ch] = 1'b1;
          else if (r && ndro_c[k] == 0)     mstore[k][ch] = 1'b0;
        end
        mcnt[k] = mcnt[k] + $countones(eviol);
        if (mcnt[k] > max_c[k]) mcnt[k] = max_c[k];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk_dut(0, if0.out, if0.store, if0.viol, 32'(if0.viol_cnt));
    chk_dut(1, if1.out, if1.store, if1.viol, 32'(if1.viol_cnt));
    chk_dut(2, if2.out, if2.store, if2.viol, 32'(if2.viol_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; set = '0; clr = '0; rd = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0);

    // Plain set then late readout.
    idle(5);
    step(1'b1, 4'b0001, '0, 1'b0);
    idle(9);
    step(1'b1, '0, '0, 1'b1);
    idle(3);

    // Setup window: k=2 violates, k=3 does not.
    step(1'b1, 4'b0010, '0, 1'b0);
    idle(1);
    step(1'b1, '0, '0, 1'b1);
    idle(4);
    step(1'b1, 4'b0010, '0, 1'b0);
    idle(2);
    step(1'b1, '0, '0, 1'b1);
    idle(4);

    // Hold window: k=2 violates, k=3 does not; then same-cycle set+rd.
    step(1'b1, '0, '0, 1'b1);
    idle(1);
    step(1'b1, 4'b0100, '0, 1'b0);
    idle(4);
    step(1'b1, '0, '0, 1'b1);
    idle(2);
    step(1'b1, 4'b0100, '0, 1'b0);
    idle(4);
    step(1'b1, 4'b1000, '0, 1'b1);
    idle(4);

    // Repeated readout, clear, and clear-beats-set.
    step(1'b1, 4'b0001, '0, 1'b0);
    idle(9);
    step(1'b1, '0, '0, 1'b1);
    idle(4);
    step(1'b1, '0, '0, 1'b1);
    step(1'b1, '0, 4'b0001, 1'b0);
    idle(2);
    step(1'b1, '0, '0, 1'b1);
    step(1'b1, 4'b0001, 4'b0001, 1'b0);
    idle(4);

    // All channels violate together, repeatedly, to saturate the narrow counter.
    step(1'b1, 4'b1111, '0, 1'b1);
    step(1'b1, 4'b1111, '0, 1'b1);
    step(1'b1, 4'b1111, '0, 1'b1);
    idle(4);

    // Reset between set and rd discards the pending state.
    step(1'b1, 4'b0001, '0, 1'b0);
    idle(4);
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b1);
    idle(4);

    // Random traffic, including occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      logic [CH-1:0] s, c;
      logic r, rn;
      for (int ch = 0; ch < CH; ch++) begin
        s[ch] = ($urandom_range(0, 5) == 0);
        c[ch] = ($urandom_range(0, 11) == 0);
      end
      r  = ($urandom_range(0, 4) == 0);
      rn = ($urandom_range(0, 99) != 0);
      step(rn, s, c, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dro_bank.md
Name: dro_bank

Overview:
Parametrised, clocked, multi-channel model of the DRO storage cell with built-in timing-violation checking. Each channel latches a set strobe and releases it as a one-cycle out pulse on a global readout strobe (rd). A per-channel setup/hold window checker flags set/rd events that are too close together, and a saturating counter totals the violations. Used as the behavioural reference for cell-array benches and for timing-violation regression runs.

Parameters:
CH, 4, number of independent storage channels (>=1)
SETUP_CYC, 3, minimum clk cycles from set to rd; rd at set+k with 0<=k<SETUP_CYC is a setup violation (>=1)
HOLD_CYC, 2, minimum clk cycles from rd to next set; set at rd+k with 1<=k<=HOLD_CYC is a hold violation (>=0; 0 disables hold check)
CNT_W, 8, width of violation counter
NDRO, 0, 0 = destructive readout (rd clears store); 1 = non-destructive (store kept, cleared only by clr)

Ports:
clk  input  1  system clock, all activity on rising edge
reset_n  input  1  synchronous, active-low reset
set  input  CH  per-channel set strobe, one-cycle pulse
clr  input  CH  per-channel clear strobe
rd  input  1  global readout strobe shared by all channels
out  output  CH  readout pulse, registered
store  output  CH  current stored state per channel
viol  output  CH  one-cycle violation pulse per channel
viol_cnt  output  CNT_W  saturating count of violation events

Behaviour:
- Reset (reset_n=0 at clk edge): store=0, out=0, viol=0, viol_cnt=0. Set-age and rd-age timers preset to saturated (no violation may fire from pre-reset history). Reset overrides all inputs in that cycle. Reset mid-operation discards pending state; the first cycle after release behaves as a fresh start.
- Store update per channel, priority order: clr > set > rd-clear. clr[i]=1 -> store[i]=0 next cycle. Otherwise, set[i]=1 -> store[i]=1. Otherwise, if rd=1 and NDRO=0 -> store[i]=0. Otherwise hold. A set to an already-stored channel changes nothing and is not an error.
- Readout: rd=1 at cycle t -> out[i]=store[i] (value before the cycle-t update) at cycle t+1, for exactly one cycle. out=0 in all other cycles. Latency is 1 cycle.
- Simultaneous set[i] and rd in the same cycle: out[i] reflects the old store; store[i]=1 afterwards in both modes.
- Timers: per-channel set-age counts cycles since the last set[i] and saturates at SETUP_CYC. A single rd-age counts cycles since the last rd and saturates at HOLD_CYC+1. Both are ceil(log2) sized.
- Setup violation: rd at cycle t while set-age[i]<SETUP_CYC, counting a same-cycle set as age 0.
- Hold violation: set[i] at cycle t while 1<=rd-age<=HOLD_CYC.
- A same-cycle set+rd counts only as a setup violation; it is never double-counted.
- Violation timing: viol[i] pulses at t+1. Setup and hold on the same channel in one cycle still produce a single pulse. clr never triggers or suppresses checks. Violations do not alter the store/out logic.
- viol_cnt increments by popcount(viol) each cycle and saturates at 2^CNT_W-1, with no wrap.

Test Plan:
- Reset, then set[0] at cycle 10 and rd at 20 -> out=4'b0001 at cycle 21 only; store[0]=0 from cycle 21; viol=0; viol_cnt=0.
- set[1] at 10, rd at 12 (k=2<3) -> out[1]=1 and viol[1]=1 at cycle 13; viol_cnt=1. Repeating with rd at 13 (k=3) gives no violation.
- rd at 30, set[2] at 32 -> viol[2]=1 at 33, store[2]=1. Repeating with set at 33 gives no violation. Same-cycle set[3]+rd at 40 -> out[3]=old store (0), store[3]=1, exactly one viol[3], counter increments by 1.
- NDRO=1: set[0] at 10, rd at 20 and 25 -> out[0] pulses at 21 and 26, store[0] stays 1. clr[0] at 27 -> store[0]=0 at 28, and rd at 30 gives out=0. Same-cycle clr[0]+set[0] -> store[0]=0.
- CNT_W=2: all four channels violate in one cycle, then again -> viol_cnt=3 and holds at 3.
- reset_n=0 at cycle 15 between set (10) and rd (16) -> store=0, no out pulse at 17, no viol after release.
